// File: rtl/horner_pkg.sv
// Shared types and default sizes for the Horner polynomial evaluator.
package horner_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_X_W    = 8;
  localparam int DEFAULT_DEGREE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/horner_step.sv
// One Horner step: acc*x + coef, reduced to DATA_W bits.
// Define SATURATION_EN to clamp instead of wrapping two's-complement.
module horner_step
  import horner_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int X_W    = DEFAULT_X_W
) (
  input  logic signed [DATA_W-1:0] acc_i,
  input  logic signed [X_W-1:0]    x_i,
  input  logic signed [DATA_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] acc_o,
  output logic                     clamp_o
);

  localparam int PROD_W = DATA_W + X_W;
  localparam int SUM_W  = PROD_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;

  always_comb begin
    prod = PROD_W'(acc_i) * PROD_W'(x_i);
    sum  = SUM_W'(prod) + SUM_W'(coef_i);
  end

`ifdef SATURATION_EN
  localparam logic signed [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // The sum fits in DATA_W exactly when every bit above the DATA_W sign bit copies it.
  logic [SUM_W-DATA_W:0] upper;

  always_comb begin
    upper = sum[SUM_W-1:DATA_W-1];
    if ((&upper) || !(|upper)) begin
      acc_o   = sum[DATA_W-1:0];
      clamp_o = 1'b0;
    end else begin
      acc_o   = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      clamp_o = 1'b1;
    end
  end
`else
  always_comb begin
    acc_o   = DATA_W'(sum);
    clamp_o = 1'b0;
  end
`endif

endmodule

// File: rtl/horner_solver.sv
// Sequential Horner evaluator of p(x) = sum coef[k]*x^k, one step per cycle.
// Overflow handling is selected by the SATURATION_EN macro (see horner_step).
module horner_solver
  import horner_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int X_W    = DEFAULT_X_W,
  parameter int DEGREE = DEFAULT_DEGREE
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic signed [X_W-1:0]          x,
  input  logic [(DEGREE+1)*DATA_W-1:0]   coefs,
  output logic signed [DATA_W-1:0]       result,
  output logic                           ready,
  output logic                           valid,
  output logic                           overflow
);

  localparam int CNT_W = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     ovf_acc_q, ovf_acc_d;
  logic                     overflow_q, overflow_d;
  logic                     capture;

  logic signed [X_W-1:0]    x_q;
  logic signed [DATA_W-1:0] coef_q [DEGREE+1];
  logic [CNT_W-1:0]         coef_idx;
  logic signed [DATA_W-1:0] step_acc;
  logic                     step_clamp;

  assign coef_idx = cnt_q - CNT_W'(1);

  horner_step #(
    .DATA_W (DATA_W),
    .X_W    (X_W)
  ) u_step (
    .acc_i   (acc_q),
    .x_i     (x_q),
    .coef_i  (coef_q[coef_idx]),
    .acc_o   (step_acc),
    .clamp_o (step_clamp)
  );

  // NOTE: operand captures carry no reset; they are only read in RUN, which is
  // reachable solely through a capture, so a reset value would never be observed.
  always_ff @(posedge clock) begin
    if (capture) begin
      x_q <= x;
      for (int k = 0; k <= DEGREE; k++) begin
        coef_q[k] <= coefs[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    ovf_acc_d  = ovf_acc_q;
    overflow_d = overflow_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          acc_d     = coefs[DEGREE*DATA_W +: DATA_W];
          cnt_d     = CNT_W'(DEGREE);
          ovf_acc_d = 1'b0;
          state_d   = (DEGREE == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d     = step_acc;
        ovf_acc_d = ovf_acc_q | step_clamp;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Publish result and overflow together so both hold until the next DONE.
        result_d   = acc_q;
        overflow_d = ovf_acc_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ovf_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      ovf_acc_q  <= ovf_acc_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign result   = result_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_horner_solver.sv
// Directed, table-driven bench for horner_solver (DEGREE=2 and DEGREE=0 instances).
module tb_horner_solver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset, start, start0;
  logic signed [7:0]  x, x0;
  logic [47:0]        coefs;
  logic [15:0]        coefs0;
  logic signed [15:0] result, result0;
  logic               ready, valid, overflow;
  logic               ready0, valid0, overflow0;

  horner_solver #(.DATA_W(16), .X_W(8), .DEGREE(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .coefs    (coefs),
    .result   (result),
    .ready    (ready),
    .valid    (valid),
    .overflow (overflow)
  );

  horner_solver #(.DATA_W(16), .X_W(8), .DEGREE(0)) dut0 (
    .clock    (clock),
    .reset    (reset),
    .start    (start0),
    .x        (x0),
    .coefs    (coefs0),
    .result   (result0),
    .ready    (ready0),
    .valid    (valid0),
    .overflow (overflow0)
  );

  typedef struct {
    logic signed [7:0]  x;
    logic signed [15:0] c0;
    logic signed [15:0] c1;
    logic signed [15:0] c2;
    logic signed [15:0] exp_res;
    logic               exp_ovf;
  } vec_t;

  vec_t vecs [7];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start one evaluation on the DEGREE=2 instance, scramble inputs after
  // acceptance, and watch a bounded window for the single valid pulse.
  task automatic run_eval(input vec_t v, input string tag);
    int     first;
    int     pulses;
    longint res_at;
    check({tag, "_ready"}, ready, 1);
    x     = v.x;
    coefs = {v.c2, v.c1, v.c0};
    start = 1'b1;
    tick();
    start  = 1'b0;
    x      = 8'sh55;
    coefs  = '1;
    first  = 0;
    pulses = 0;
    res_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (valid) begin
        pulses++;
        if (first == 0) first = i;
        res_at = result;
      end
    end
    check({tag, "_latency"}, first, 3);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_result"}, res_at, v.exp_res);
    check({tag, "_hold"}, result, v.exp_res);
    check({tag, "_ovf"}, overflow, v.exp_ovf);
  endtask

  initial begin
    int     pulses;
    int     first;
    int     last;
    vec_t   v;

    vecs[0] = '{x: 3,    c0: 5,  c1: -1, c2: 2,  exp_res: 20,  exp_ovf: 1'b0};
    vecs[1] = '{x: -4,   c0: 0,  c1: 0,  c2: 1,  exp_res: 16,  exp_ovf: 1'b0};
    vecs[2] = '{x: 0,    c0: 7,  c1: 3,  c2: 9,  exp_res: 7,   exp_ovf: 1'b0};
    vecs[3] = '{x: -1,   c0: 1,  c1: 1,  c2: 1,  exp_res: 1,   exp_ovf: 1'b0};
    vecs[4] = '{x: 2,    c0: -3, c1: 0,  c2: -5, exp_res: -23, exp_ovf: 1'b0};
`ifdef SATURATION_EN
    vecs[5] = '{x: 127,  c0: 0,  c1: 0,  c2: 32767, exp_res: 32767, exp_ovf: 1'b1};
    vecs[6] = '{x: -128, c0: 0,  c1: 0,  c2: 32767, exp_res: 32767, exp_ovf: 1'b1};
`else
    vecs[5] = '{x: 127,  c0: 0,  c1: 0,  c2: 32767, exp_res: 16639,  exp_ovf: 1'b0};
    vecs[6] = '{x: -128, c0: 0,  c1: 0,  c2: 32767, exp_res: -16384, exp_ovf: 1'b0};
`endif

    // Reset with start held high: start must not be taken.
    reset  = 1'b1;
    start  = 1'b1;
    start0 = 1'b1;
    x      = 8'sd3;
    x0     = 8'sd3;
    coefs  = {16'sd2, -16'sd1, 16'sd5};
    coefs0 = 16'sd9;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready0", ready0, 1);
    reset  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    tick();
    check("post_rst_idle", ready, 1);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_eval(v, $sformatf("vec%0d", i));
    end

    // Start pulsed while RUN is in progress must be ignored.
    x     = -8'sd4;
    coefs = {16'sd1, 16'sd0, 16'sd0};
    start = 1'b1;
    tick();
    check("busy_ready", ready, 0);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 10; i++) begin
      start = (i == 1 || i == 2);
      tick();
      if (valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    check("busy_pulses", pulses, 1);
    check("busy_latency", first, 3);
    check("busy_result", result, 16);

    // DEGREE=0: valid one cycle after acceptance.
    x0     = 8'sd55;
    coefs0 = 16'hFFF9;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    x0     = -8'sd3;
    coefs0 = 16'sd100;
    check("deg0_valid_early", valid0, 0);
    check("deg0_ready_busy", ready0, 0);
    tick();
    check("deg0_valid", valid0, 1);
    check("deg0_result", result0, -7);
    tick();
    check("deg0_valid_drop", valid0, 0);
    check("deg0_hold", result0, -7);
    check("deg0_ovf", overflow0, 0);

    // Reset during the second RUN cycle aborts the evaluation.
    x     = 8'sd3;
    coefs = {16'sd2, -16'sd1, 16'sd5};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_result", result, 0);
    check("abort_valid", valid, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    v = vecs[0];
    run_eval(v, "after_abort");

    // start held high: back-to-back evaluations every DEGREE+2 cycles.
    x     = 8'sd3;
    coefs = {16'sd2, -16'sd1, 16'sd5};
    start = 1'b1;
    tick();
    pulses = 0;
    first  = 0;
    last   = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (valid) begin
        pulses++;
        if (first == 0) first = i;
        last = i;
        check($sformatf("stream_result_%0d", i), result, 20);
      end
    end
    start = 1'b0;
    check("stream_pulses", pulses, 3);
    check("stream_first", first, 3);
    check("stream_span", last - first, 8);
    repeat (6) tick();
    check("stream_drained", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
